// File: rtl/arm_pkg.sv
// Shared fetch/decode definitions: fetch FSM states, pc_in_sel encodings, reset PC.
package arm_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      EXEC,
      HALT,
      FAULT
   } fetch_state_t;

   // pc_in_sel encodings; the unused code 2'd3 behaves as PC_SEL_PLUS4
   localparam logic [1:0] PC_SEL_BRANCH = 2'd0;
   localparam logic [1:0] PC_SEL_PLUS4  = 2'd1;
   localparam logic [1:0] PC_SEL_HOLD   = 2'd2;

   localparam logic [31:0] ARM_RESET_PC = 32'h0040_0000;

endpackage

// File: rtl/arm_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and instruction memory.
interface arm_fetch_unit_if;

   logic        req;
   logic [31:0] addr;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (output req, addr, input rvalid, rdata);
   modport slave  (input req, addr, output rvalid, rdata);

endinterface

// File: rtl/arm_next_pc.sv
// Combinational next-PC selection from the decoder's pc_in_sel and the branch target.
module arm_next_pc
   import arm_pkg::*;
(
   input  logic [31:0] pc_i,
   input  logic [1:0]  pc_in_sel_i,
   input  logic [31:0] branch_addr_i,
   output logic [31:0] next_pc_o,
   output logic [31:0] pc_plus4_o
);

   // Branch targets are forced to word alignment; the low bits carry no meaning.
   logic unused_branch_low;
   assign unused_branch_low = ^branch_addr_i[1:0];

   assign pc_plus4_o = pc_i + 32'd4;

   always_comb begin
      next_pc_o = pc_plus4_o;
      case (pc_in_sel_i)
         PC_SEL_BRANCH: next_pc_o = {branch_addr_i[31:2], 2'b00};
         PC_SEL_HOLD:   next_pc_o = pc_i;
         default:       next_pc_o = pc_plus4_o;
      endcase
   end

endmodule

// File: rtl/arm_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over req/rvalid, presents one inst per EXEC slot.
// Optional statistics counters are built when ARM_FETCH_STATS_EN is defined.
module arm_fetch_unit
   import arm_pkg::*;
#(
   parameter logic [31:0] RESET_PC = ARM_RESET_PC,
   parameter int unsigned MAX_WAIT = 16
)(
   input  logic               clk,
   input  logic               rst,
   arm_fetch_unit_if.master   imem,
   output logic [31:0]        inst_o,
   output logic               inst_valid_o,
   output logic [31:0]        pc_o,
   output logic [31:0]        pc_plus4_o,
   input  logic               ex_stall_i,
   input  logic               pc_we_i,
   input  logic [1:0]         pc_in_sel_i,
   input  logic [31:0]        branch_addr_i,
   input  logic               halted_i,
   output logic               halt_out_o,
   output logic               fetch_fault_o,
   output logic [31:0]        fetch_count_o,
   output logic [31:0]        stall_count_o
);

   // Wait counter holds 0..MAX_WAIT-1; reaching the limit on a missed cycle faults.
   localparam int WW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
   localparam logic [WW-1:0] WAIT_LIMIT = WW'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);

   fetch_state_t  state_q;
   logic [31:0]   pc_q;
   logic [31:0]   inst_q;
   logic          req_q;
   logic          valid_q;
   logic          halt_q;
   logic          fault_q;
   logic [WW-1:0] wait_q;
   logic [31:0]   next_pc_d;

   arm_next_pc u_next_pc (
      .pc_i          (pc_q),
      .pc_in_sel_i   (pc_in_sel_i),
      .branch_addr_i (branch_addr_i),
      .next_pc_o     (next_pc_d),
      .pc_plus4_o    (pc_plus4_o)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         inst_q  <= '0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
         halt_q  <= 1'b0;
         fault_q <= 1'b0;
         wait_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               req_q   <= 1'b1;
               wait_q  <= '0;
               state_q <= REQ;
            end
            REQ: begin
               if (imem.rvalid) begin
                  inst_q  <= imem.rdata;
                  req_q   <= 1'b0;
                  valid_q <= 1'b1;
                  state_q <= EXEC;
               end else if ((MAX_WAIT != 0) && (wait_q == WAIT_LIMIT)) begin
                  req_q   <= 1'b0;
                  fault_q <= 1'b1;
                  state_q <= FAULT;
               end else begin
                  wait_q <= wait_q + 1'b1;
               end
            end
            EXEC: begin
               // A stalled slot keeps pc and inst frozen and ignores the decoder.
               if (!ex_stall_i) begin
                  valid_q <= 1'b0;
                  if (halted_i) begin
                     halt_q  <= 1'b1;
                     state_q <= HALT;
                  end else begin
                     if (pc_we_i) begin
                        pc_q <= next_pc_d;
                     end
                     req_q   <= 1'b1;
                     wait_q  <= '0;
                     state_q <= REQ;
                  end
               end
            end
            HALT, FAULT: ;
            default: ;
         endcase
      end
   end

   assign imem.req      = req_q;
   assign imem.addr     = pc_q;
   assign inst_o        = inst_q;
   assign inst_valid_o  = valid_q;
   assign pc_o          = pc_q;
   assign halt_out_o    = halt_q;
   assign fetch_fault_o = fault_q;

`ifdef ARM_FETCH_STATS_EN
   logic [31:0] fetch_count_q;
   logic [31:0] stall_count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_count_q <= '0;
         stall_count_q <= '0;
      end else begin
         if ((state_q == EXEC) && !ex_stall_i && (fetch_count_q != 32'hFFFF_FFFF)) begin
            fetch_count_q <= fetch_count_q + 32'd1;
         end
         if ((state_q == REQ) && !imem.rvalid && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_q <= stall_count_q + 32'd1;
         end
      end
   end

   assign fetch_count_o = fetch_count_q;
   assign stall_count_o = stall_count_q;
`else
   assign fetch_count_o = '0;
   assign stall_count_o = '0;
`endif

endmodule
